// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory read port: one word request, held until a single-cycle ack.
// The master holds imem_req/imem_addr stable until imem_ack; the slave returns imem_rdata with imem_ack.
interface instr_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds PC, reads imem over req/ack, loads IR and pulses W_IR_valid (3 cycles with zero-wait memory).
// Memory stalls hold the request up to TIMEOUT cycles, then the unit latches a sticky fault until reset.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      write_ir,
  input  logic                      write_pc,
  input  logic [1:0]                pc_s,
  input  logic [31:0]               b_data,
  input  logic [31:0]               f_data,
  instr_fetch_unit_if.master        imem,
  output logic [31:0]               IR,
  output logic                      W_IR_valid,
  output logic [31:0]               pc,
  output logic                      fetch_fault
);

  typedef enum logic [1:0] {
    F_IDLE  = 2'b00,
    F_REQ   = 2'b01,
    F_DONE  = 2'b10,
    F_FAULT = 2'b11
  } state_t;

  localparam int            CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  state_t        r_state,  w_state_nxt;
  logic [31:0]   r_pc,     w_pc_nxt;
  logic [31:0]   r_ir,     w_ir_nxt;
  logic          r_ir_vld, w_ir_vld_nxt;
  logic          r_req,    w_req_nxt;
  logic [31:0]   r_addr,   w_addr_nxt;
  logic          r_fault,  w_fault_nxt;
  logic [CW-1:0] r_cnt,    w_cnt_nxt;
  logic [31:0]   w_redir_pc;

  // Redirect target as seen in F_IDLE; low address bits are forced to a word boundary.
  always_comb begin
    w_redir_pc = r_pc;
    if (write_pc) begin
      case (pc_s)
        2'b01:   w_redir_pc = b_data & 32'hFFFF_FFFC;
        2'b10:   w_redir_pc = f_data & 32'hFFFF_FFFC;
        default: w_redir_pc = r_pc;
      endcase
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_pc_nxt     = r_pc;
    w_ir_nxt     = r_ir;
    w_ir_vld_nxt = 1'b0;
    w_req_nxt    = r_req;
    w_addr_nxt   = r_addr;
    w_fault_nxt  = r_fault;
    w_cnt_nxt    = r_cnt;

    case (r_state)
      F_IDLE: begin
        w_pc_nxt = w_redir_pc;
        if (write_ir) begin
          w_state_nxt = F_REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = w_redir_pc;
          w_cnt_nxt   = '0;
        end
      end

      F_REQ: begin
        // An ack in the last allowed cycle still completes the fetch.
        if (imem.imem_ack) begin
          w_state_nxt  = F_DONE;
          w_ir_nxt     = imem.imem_rdata;
          w_ir_vld_nxt = 1'b1;
          w_req_nxt    = 1'b0;
          if (write_pc && (pc_s == 2'b00)) begin
            w_pc_nxt = r_pc + 32'd4;
          end
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = F_FAULT;
          w_req_nxt   = 1'b0;
          w_fault_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CW'(1);
        end
      end

      // write_ir is still asserted here by the FSM; it must not restart a fetch.
      F_DONE: begin
        w_state_nxt = F_IDLE;
      end

      F_FAULT: begin
        w_state_nxt = F_FAULT;
      end

      default: begin
        w_state_nxt = F_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= F_IDLE;
      r_pc     <= RESET_PC;
      r_ir     <= '0;
      r_ir_vld <= 1'b0;
      r_req    <= 1'b0;
      r_addr   <= '0;
      r_fault  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_pc     <= w_pc_nxt;
      r_ir     <= w_ir_nxt;
      r_ir_vld <= w_ir_vld_nxt;
      r_req    <= w_req_nxt;
      r_addr   <= w_addr_nxt;
      r_fault  <= w_fault_nxt;
      r_cnt    <= w_cnt_nxt;
    end
  end

  assign imem.imem_req  = r_req;
  assign imem.imem_addr = r_addr;
  assign IR             = r_ir;
  assign W_IR_valid     = r_ir_vld;
  assign pc             = r_pc;
  assign fetch_fault    = r_fault;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: random fetches, redirects and stalls against a PC/IR reference model.
module tb_instr_fetch_unit;
  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        write_ir = 1'b0;
  logic        write_pc = 1'b0;
  logic [1:0]  pc_s = 2'b00;
  logic [31:0] b_data = '0;
  logic [31:0] f_data = '0;
  logic [31:0] IR;
  logic        W_IR_valid;
  logic [31:0] pc;
  logic        fetch_fault;

  instr_fetch_unit_if imem_bus();

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .write_ir    (write_ir),
    .write_pc    (write_pc),
    .pc_s        (pc_s),
    .b_data      (b_data),
    .f_data      (f_data),
    .imem        (imem_bus),
    .IR          (IR),
    .W_IR_valid  (W_IR_valid),
    .pc          (pc),
    .fetch_fault (fetch_fault)
  );

  int          checks = 0;
  int          failures = 0;
  int          pulses = 0;
  logic [31:0] m_pc = '0;
  logic [31:0] m_ir = '0;

  always #5 clk = ~clk;

  always @(negedge clk) if (W_IR_valid === 1'b1) pulses++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    write_ir = 1'b0; write_pc = 1'b0; pc_s = 2'b00;
    imem_bus.imem_ack = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_pc = 32'h0; m_ir = 32'h0;
  endtask

  // One complete fetch: optional redirect in F_IDLE, waits stall cycles, ack with PC+4.
  task automatic do_fetch(input logic [1:0] sel, input logic [31:0] tgt, input int waits,
                          input logic inject_bx, input logic [31:0] rdata);
    if (sel == 2'b01) begin b_data = tgt; m_pc = {tgt[31:2], 2'b00}; end
    if (sel == 2'b10) begin f_data = tgt; m_pc = {tgt[31:2], 2'b00}; end
    write_ir = 1'b1; write_pc = (sel == 2'b01) || (sel == 2'b10); pc_s = sel;
    tick();
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL fetch_req got=%b exp=1", imem_bus.imem_req); end
    checks++; if (imem_bus.imem_addr !== m_pc) begin failures++; $display("FAIL fetch_addr got=%h exp=%h", imem_bus.imem_addr, m_pc); end
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL fetch_pc_req got=%h exp=%h", pc, m_pc); end
    write_pc = inject_bx; pc_s = 2'b01; b_data = 32'h0000_0400;
    for (int i = 0; i < waits; i++) begin
      tick();
      checks++; if (imem_bus.imem_req !== 1'b1 || imem_bus.imem_addr !== m_pc) begin
        failures++; $display("FAIL stall_hold req=%b addr=%h exp_addr=%h", imem_bus.imem_req, imem_bus.imem_addr, m_pc);
      end
    end
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = rdata; m_ir = rdata;
    write_pc = 1'b1; pc_s = 2'b00;
    tick();
    imem_bus.imem_ack = 1'b0; write_pc = 1'b0;
    m_pc = m_pc + 32'd4;
    checks++; if (W_IR_valid !== 1'b1) begin failures++; $display("FAIL ir_valid_set got=%b exp=1", W_IR_valid); end
    checks++; if (IR !== m_ir) begin failures++; $display("FAIL ir_value got=%h exp=%h", IR, m_ir); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL req_drop got=%b exp=0", imem_bus.imem_req); end
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL pc_inc got=%h exp=%h", pc, m_pc); end
    tick();
    checks++; if (W_IR_valid !== 1'b0) begin failures++; $display("FAIL ir_valid_pulse got=%b exp=0", W_IR_valid); end
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL no_refetch_done got=%b exp=0", imem_bus.imem_req); end
    write_ir = 1'b0;
  endtask

  task automatic test_reset();
    write_ir = 1'b1;
    #1 rst = 1'b0;
    #2;
    checks++; if (pc !== 32'h0 || IR !== 32'h0) begin failures++; $display("FAIL reset_pc_ir pc=%h ir=%h exp=0", pc, IR); end
    checks++; if (imem_bus.imem_req !== 1'b0 || imem_bus.imem_addr !== 32'h0) begin
      failures++; $display("FAIL reset_bus req=%b addr=%h exp=0", imem_bus.imem_req, imem_bus.imem_addr);
    end
    checks++; if (W_IR_valid !== 1'b0 || fetch_fault !== 1'b0) begin
      failures++; $display("FAIL reset_flags vld=%b fault=%b exp=0", W_IR_valid, fetch_fault);
    end
    tick();
    rst = 1'b1; m_pc = 32'h0; m_ir = 32'h0;
    do_fetch(2'b00, 32'h0, 2, 1'b0, 32'hE081_0002);
    checks++; if (IR !== 32'hE081_0002 || pc !== 32'h4) begin
      failures++; $display("FAIL first_fetch ir=%h pc=%h exp=e0810002/4", IR, pc);
    end
  endtask

  task automatic test_back_to_back();
    int p0;
    apply_reset();
    p0 = pulses;
    for (int i = 0; i < 3; i++) do_fetch(2'b00, 32'h0, 0, 1'b0, $urandom);
    checks++; if (pc !== 32'hC) begin failures++; $display("FAIL b2b_pc got=%h exp=0000000c", pc); end
    checks++; if (pulses - p0 !== 3) begin failures++; $display("FAIL b2b_pulses got=%0d exp=3", pulses - p0); end
  endtask

  task automatic test_redirect();
    logic [31:0] t;
    write_pc = 1'b1; pc_s = 2'b00;
    tick();
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL idle_pcs00 got=%h exp=%h", pc, m_pc); end
    pc_s = 2'b11;
    tick();
    checks++; if (pc !== m_pc) begin failures++; $display("FAIL idle_pcs11 got=%h exp=%h", pc, m_pc); end
    pc_s = 2'b10; f_data = 32'h0000_0057; m_pc = 32'h0000_0054;
    tick();
    write_pc = 1'b0;
    checks++; if (pc !== m_pc || imem_bus.imem_req !== 1'b0) begin
      failures++; $display("FAIL idle_redirect pc=%h req=%b exp=%h/0", pc, imem_bus.imem_req, m_pc);
    end
    do_fetch(2'b10, 32'h0000_0103, 1, 1'b0, $urandom);
    do_fetch(2'b01, 32'h0000_0200, 0, 1'b0, $urandom);
    for (int i = 0; i < 4; i++) begin
      t = $urandom;
      do_fetch(($urandom_range(0, 1) != 0) ? 2'b01 : 2'b10, t, $urandom_range(0, TO - 1), 1'b0, $urandom);
    end
  endtask

  task automatic test_ignore_and_wrap();
    logic [31:0] old;
    old = m_pc;
    do_fetch(2'b00, 32'h0, 2, 1'b1, $urandom);
    checks++; if (pc !== old + 32'd4) begin failures++; $display("FAIL bx_in_req pc=%h exp=%h", pc, old + 32'd4); end
    do_fetch(2'b10, 32'hFFFF_FFFF, $urandom_range(0, TO - 1), 1'b0, $urandom);
    checks++; if (pc !== 32'h0) begin failures++; $display("FAIL pc_wrap got=%h exp=00000000", pc); end
  endtask

  task automatic test_stray_ack();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = ~m_ir;
    tick();
    imem_bus.imem_ack = 1'b0;
    tick();
    checks++; if (IR !== m_ir || W_IR_valid !== 1'b0) begin
      failures++; $display("FAIL idle_ack ir=%h vld=%b exp=%h/0", IR, W_IR_valid, m_ir);
    end
  endtask

  task automatic test_timeout();
    int cyc;
    int p0;
    p0 = pulses;
    cyc = 0;
    write_ir = 1'b1;
    tick();
    while (imem_bus.imem_req === 1'b1 && cyc < 20) begin cyc++; tick(); end
    write_ir = 1'b0;
    checks++; if (cyc !== TO) begin failures++; $display("FAIL timeout_len got=%0d exp=%0d", cyc, TO); end
    checks++; if (fetch_fault !== 1'b1) begin failures++; $display("FAIL fault_set got=%b exp=1", fetch_fault); end
    checks++; if (IR !== m_ir || pc !== m_pc) begin
      failures++; $display("FAIL fault_state ir=%h pc=%h exp=%h/%h", IR, pc, m_ir, m_pc);
    end
    write_ir = 1'b1; write_pc = 1'b1; pc_s = 2'b10; f_data = 32'h0000_0800;
    for (int i = 0; i < 6; i++) begin
      imem_bus.imem_ack = i[0]; imem_bus.imem_rdata = $urandom;
      tick();
      checks++; if (imem_bus.imem_req !== 1'b0 || fetch_fault !== 1'b1) begin
        failures++; $display("FAIL fault_absorb req=%b fault=%b exp=0/1", imem_bus.imem_req, fetch_fault);
      end
    end
    imem_bus.imem_ack = 1'b0; write_ir = 1'b0; write_pc = 1'b0;
    tick();
    checks++; if (IR !== m_ir || pc !== m_pc) begin
      failures++; $display("FAIL fault_ignore ir=%h pc=%h exp=%h/%h", IR, pc, m_ir, m_pc);
    end
    checks++; if (pulses !== p0) begin failures++; $display("FAIL fault_no_valid got=%0d exp=%0d", pulses - p0, 0); end
  endtask

  task automatic test_reset_mid_req();
    apply_reset();
    checks++; if (fetch_fault !== 1'b0) begin failures++; $display("FAIL fault_cleared got=%b exp=0", fetch_fault); end
    write_ir = 1'b1;
    tick();
    tick();
    checks++; if (imem_bus.imem_req !== 1'b1) begin failures++; $display("FAIL midreq_pre got=%b exp=1", imem_bus.imem_req); end
    #2 rst = 1'b0;
    #1;
    checks++; if (imem_bus.imem_req !== 1'b0) begin failures++; $display("FAIL midreq_async got=%b exp=0", imem_bus.imem_req); end
    checks++; if (pc !== 32'h0 || IR !== 32'h0) begin failures++; $display("FAIL midreq_regs pc=%h ir=%h exp=0", pc, IR); end
    write_ir = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hDEAD_BEEF;
    tick();
    imem_bus.imem_ack = 1'b0;
    checks++; if (IR !== 32'h0 || W_IR_valid !== 1'b0) begin
      failures++; $display("FAIL late_ack ir=%h vld=%b exp=0/0", IR, W_IR_valid);
    end
    tick();
    checks++; if (imem_bus.imem_req !== 1'b0 || W_IR_valid !== 1'b0) begin
      failures++; $display("FAIL late_ack_idle req=%b vld=%b exp=0/0", imem_bus.imem_req, W_IR_valid);
    end
  endtask

  initial begin
    imem_bus.imem_ack = 1'b0;
    imem_bus.imem_rdata = '0;
    test_reset();
    test_back_to_back();
    test_redirect();
    test_ignore_and_wrap();
    test_stray_ack();
    test_timeout();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
